sopc_boot_ctrl: RTL and testbench

- Synthesisable, parametrised sequencer that replaces the hard-coded simulation harness of the minimal SOPC.
- Streams a program image into the instruction ROM write port and holds the CPU in reset for a programmable number of cycles.
- Runs the CPU until it halts or a cycle budget expires, then freezes it and streams out a snapshot of the first DUMP_REGS general registers.
- Sits between a host/loader and the openmips core plus inst ROM inside the SOPC top.

---
 rtl/sopc_boot_ctrl_pkg.sv | 31 +++
 rtl/sopc_cycle_counter.sv | 38 +++
 rtl/sopc_boot_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_sopc_boot_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sopc_boot_ctrl_pkg.sv
// sopc_boot_ctrl_pkg
//   Shared definitions for the SOPC boot/run/dump sequencer:
//   - sequencer state and dump phase encodings
//   - default data-path widths
//   - reset polarity constants (match `RstEnable / `RstDisable of the core)
package sopc_boot_ctrl_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic RST_ENABLE  = 1'b1;
  localparam logic RST_DISABLE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN,
    ST_DUMP,
    ST_DONE
  } boot_state_e;

  // PH_ADDR: debug address presented, read data captured at end of cycle.
  // PH_BEAT: captured value offered on the result stream.
  typedef enum logic {
    PH_ADDR,
    PH_BEAT
  } dump_phase_e;

endpackage

// File: rtl/sopc_cycle_counter.sv
// sopc_cycle_counter
//   Saturating up-counter with synchronous clear and enable.
//   Ports:
//     clk, rst  - clock, synchronous active-high reset
//     clr       - synchronous clear (to zero)
//     en        - count enable
//     terminal  - compare value
//     count     - current count
//     at_term   - count == terminal (combinational on the registered count)
module sopc_cycle_counter
  import sopc_boot_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] terminal,
  output logic [CNT_W-1:0] count,
  output logic             at_term
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || clr) begin
      count_reg <= '0;
    end else if (en && count_reg != '1) begin
      // Hold at all-ones instead of wrapping.
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count   = count_reg;
  assign at_term = (count_reg == terminal);

endmodule

// File: rtl/sopc_boot_ctrl.sv
// sopc_boot_ctrl
//   Boot sequencer for the minimal SOPC: loads a program image into the
//   instruction ROM, holds the core in reset, runs it until halt or budget
//   expiry, then freezes it and streams out the first DUMP_REGS registers.
//   Ports:
//     clk, rst                  - clock, synchronous active-high reset
//     start                     - begin a load (honoured in IDLE / DONE)
//     ld_valid/ready/data/last  - program image stream in
//     rom_we/addr/wdata         - instruction ROM write port
//     cpu_rst, cpu_stall        - core control
//     cpu_halt                  - core halted
//     dbg_raddr, dbg_rdata      - register-file debug read port
//     res_valid/ready/idx/data  - register dump stream out
//     busy, done, timeout       - status
//     load_words, cycles        - last load size, last run length
module sopc_boot_ctrl
  import sopc_boot_ctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int REG_AW      = REG_AW_DEF,
  parameter int HOLD_CYCLES = 2,
  parameter int RUN_CYCLES  = 100,
  parameter int DUMP_REGS   = 8,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_wdata,
  output logic              cpu_rst,
  output logic              cpu_stall,
  input  logic              cpu_halt,
  output logic [REG_AW-1:0] dbg_raddr,
  input  logic [DATA_W-1:0] dbg_rdata,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [REG_AW-1:0] res_idx,
  output logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [ADDR_W:0]   load_words,
  output logic [CNT_W-1:0]  cycles
);

  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [REG_AW-1:0] LAST_IDX  = REG_AW'(DUMP_REGS - 1);
  localparam logic [CNT_W-1:0]  HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RUN_TERM  = CNT_W'(RUN_CYCLES - 1);

  boot_state_e       state_reg, state_next;
  dump_phase_e       phase_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W:0]   load_words_reg;
  logic              rom_we_reg;
  logic [ADDR_W-1:0] rom_addr_reg;
  logic [DATA_W-1:0] rom_wdata_reg;
  logic              timeout_reg;
  logic [REG_AW-1:0] idx_reg;
  logic [DATA_W-1:0] res_data_reg;

  logic              start_ok;
  logic              accept;
  logic              hold_at_term;
  logic              run_at_term;
  logic [CNT_W-1:0]  hold_count_unused;  // only the terminal flag ends HOLD

  assign start_ok = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
  assign accept   = ld_valid && (state_reg == ST_LOAD);

  // HOLD counter restarts from zero every time HOLD is entered.
  sopc_cycle_counter #(.CNT_W(CNT_W)) u_hold_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_reg != ST_HOLD),
    .en       (state_reg == ST_HOLD),
    .terminal (HOLD_TERM),
    .count    (hold_count_unused),
    .at_term  (hold_at_term)
  );

  // RUN counter is cleared only by a new start so the last run length is
  // still visible in DUMP and DONE. Terminal compare uses the pre-increment
  // value: the cycle whose increment reaches RUN_CYCLES is the last RUN cycle.
  sopc_cycle_counter #(.CNT_W(CNT_W)) u_run_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok),
    .en       (state_reg == ST_RUN),
    .terminal (RUN_TERM),
    .count    (cycles),
    .at_term  (run_at_term)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ld_ready   = 1'b0;
    cpu_rst    = 1'b0;
    cpu_stall  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    res_valid  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cpu_rst = 1'b1;
        if (start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        cpu_rst  = 1'b1;
        ld_ready = 1'b1;
        busy     = 1'b1;
        // Last word, or the ROM is full: stop accepting.
        if (ld_valid && (ld_last || addr_reg == ADDR_MAX)) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        cpu_rst = 1'b1;
        busy    = 1'b1;
        if (hold_at_term) state_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (cpu_halt || run_at_term) state_next = ST_DUMP;
      end
      ST_DUMP: begin
        busy      = 1'b1;
        cpu_stall = 1'b1;
        res_valid = (phase_reg == PH_BEAT);
        if (phase_reg == PH_BEAT && res_ready && idx_reg == LAST_IDX) state_next = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        cpu_stall = 1'b1;
        if (start) state_next = ST_LOAD;
      end
      default: begin
        cpu_rst    = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      phase_reg      <= PH_ADDR;
      addr_reg       <= '0;
      load_words_reg <= '0;
      rom_we_reg     <= 1'b0;
      rom_addr_reg   <= '0;
      rom_wdata_reg  <= '0;
      timeout_reg    <= 1'b0;
      idx_reg        <= '0;
      res_data_reg   <= '0;
    end else begin
      // ROM write is the registered image of an accepted word.
      rom_we_reg <= accept;
      if (accept) begin
        rom_addr_reg   <= addr_reg;
        rom_wdata_reg  <= ld_data;
        addr_reg       <= addr_reg + ADDR_W'(1);
        load_words_reg <= load_words_reg + (ADDR_W+1)'(1);
      end
      if (start_ok) begin
        addr_reg       <= '0;
        load_words_reg <= '0;
        timeout_reg    <= 1'b0;
      end
      // Halt has priority over budget expiry.
      if (state_reg == ST_RUN && !cpu_halt && run_at_term) timeout_reg <= 1'b1;
      if (state_reg == ST_RUN && state_next == ST_DUMP) begin
        idx_reg   <= '0;
        phase_reg <= PH_ADDR;
      end
      if (state_reg == ST_DUMP) begin
        if (phase_reg == PH_ADDR) begin
          res_data_reg <= dbg_rdata;
          phase_reg    <= PH_BEAT;
        end else if (res_ready) begin
          phase_reg <= PH_ADDR;
          if (idx_reg != LAST_IDX) idx_reg <= idx_reg + REG_AW'(1);
        end
      end
    end
  end

  assign rom_we     = rom_we_reg;
  assign rom_addr   = rom_addr_reg;
  assign rom_wdata  = rom_wdata_reg;
  assign dbg_raddr  = idx_reg;
  assign res_idx    = idx_reg;
  assign res_data   = res_data_reg;
  assign timeout    = timeout_reg;
  assign load_words = load_words_reg;

endmodule

// File: tb/tb_sopc_boot_ctrl.sv
module tb_sopc_boot_ctrl;

  localparam int ADDR_W      = 10;
  localparam int DATA_W      = 32;
  localparam int REG_AW      = 5;
  localparam int HOLD_CYCLES = 2;
  localparam int RUN_CYCLES  = 100;
  localparam int DUMP_REGS   = 8;
  localparam int CNT_W       = 32;

  logic              clk = 1'b0;
  logic              rst, start, ld_valid, ld_last, cpu_halt, res_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready, rom_we, cpu_rst, cpu_stall, res_valid, busy, done, timeout;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_wdata, dbg_rdata, res_data;
  logic [REG_AW-1:0] dbg_raddr, res_idx;
  logic [ADDR_W:0]   load_words;
  logic [CNT_W-1:0]  cycles;

  logic [DATA_W-1:0] regs_tb [0:(1<<REG_AW)-1];
  logic [DATA_W-1:0] img [0:1024];

  int vectors = 0;
  int miscompares = 0;
  int mdl_load_words = 0;
  int mdl_cycles = 0;
  bit mdl_timeout = 0;

  always #5 clk = ~clk;

  // Register file model: combinational debug read.
  assign dbg_rdata = regs_tb[dbg_raddr];

  sopc_boot_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_AW(REG_AW), .HOLD_CYCLES(HOLD_CYCLES),
    .RUN_CYCLES(RUN_CYCLES), .DUMP_REGS(DUMP_REGS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .cpu_rst(cpu_rst), .cpu_stall(cpu_stall), .cpu_halt(cpu_halt),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_data(res_data),
    .busy(busy), .done(done), .timeout(timeout), .load_words(load_words), .cycles(cycles)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    vectors++;
    if ({cpu_rst, busy, done, ld_ready, rom_we, res_valid, cpu_stall, timeout} !== 8'b1000_0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want %b",
               {cpu_rst, busy, done, ld_ready, rom_we, res_valid, cpu_stall, timeout}, 8'b1000_0000);
    end
    vectors++;
    if (load_words !== '0 || cycles !== '0) begin
      miscompares++;
      $display("FAIL reset_counters: load_words=%0d cycles=%0d want 0 0", load_words, cycles);
    end
    next_cycle();
    rst = 1'b0;
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({cpu_rst, busy, ld_ready} !== 3'b100) begin
      miscompares++;
      $display("FAIL idle_after_reset: cpu_rst/busy/ld_ready=%b want 100", {cpu_rst, busy, ld_ready});
    end
  endtask

  // Starts a load from IDLE/DONE and streams img[0..n_offer-1]; ld_last on
  // word last_idx (-1: never). Returns at the negedge of the first HOLD cycle.
  task automatic load_image(input int n_offer, input int last_idx, input bit gaps);
    bit model_ready, pend_we, in_hold, first;
    int pend_addr, mdl_addr, word;
    logic [DATA_W-1:0] pend_data;
    model_ready = 1'b1; pend_we = 1'b0; in_hold = 1'b0; first = 1'b1;
    pend_addr = 0; mdl_addr = 0; word = 0; pend_data = '0;
    next_cycle();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (word < n_offer && (!gaps || $urandom_range(3) != 0)) begin
        ld_valid = 1'b1; ld_data = img[word]; ld_last = (word == last_idx);
      end else begin
        ld_valid = 1'b0; ld_data = $urandom; ld_last = 1'($urandom_range(1));
      end
      @(negedge clk);
      if (first) begin
        first = 1'b0;
        vectors++;
        if (load_words !== '0 || cycles !== '0 || timeout !== 1'b0) begin
          miscompares++;
          $display("FAIL load_init: load_words=%0d cycles=%0d timeout=%b want 0 0 0",
                   load_words, cycles, timeout);
        end
      end
      vectors++;
      if (ld_ready !== model_ready) begin
        miscompares++;
        $display("FAIL ld_ready: word %0d got %b want %b", word, ld_ready, model_ready);
      end
      vectors++;
      if (rom_we !== pend_we) begin
        miscompares++;
        $display("FAIL rom_we: word %0d got %b want %b", word, rom_we, pend_we);
      end
      if (pend_we) begin
        vectors++;
        if (rom_addr !== ADDR_W'(pend_addr) || rom_wdata !== pend_data) begin
          miscompares++;
          $display("FAIL rom_write: got addr=%0d data=%h want addr=%0d data=%h",
                   rom_addr, rom_wdata, pend_addr, pend_data);
        end
      end
      in_hold = !model_ready;
      if (in_hold) break;
      pend_we = ld_valid && model_ready;
      if (pend_we) begin
        pend_addr = mdl_addr;
        pend_data = ld_data;
        if (ld_last || mdl_addr == (1 << ADDR_W) - 1) model_ready = 1'b0;
        mdl_addr++;
        word++;
      end
      next_cycle();
    end
    vectors++;
    if (!in_hold || load_words !== (ADDR_W+1)'(mdl_addr) || cpu_rst !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL load_end: reached_hold=%b load_words=%0d cpu_rst=%b busy=%b want 1 %0d 1 1",
               in_hold, load_words, cpu_rst, busy, mdl_addr);
    end
    mdl_load_words = mdl_addr;
    $display("load: %0d words offered, %0d written", n_offer, mdl_addr);
  endtask

  // From the first HOLD cycle to DUMP entry; halt_at = RUN cycle (1-based)
  // carrying cpu_halt, 0 for none.
  task automatic run_phase(input int halt_at);
    int hold_seen, run_seen, exp_run;
    bit ended, exp_to;
    hold_seen = 1; run_seen = 0; ended = 1'b0;
    exp_to  = !(halt_at != 0 && halt_at <= RUN_CYCLES);
    exp_run = exp_to ? RUN_CYCLES : halt_at;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      next_cycle();
      ld_valid = 1'($urandom_range(1)); ld_last = 1'($urandom_range(1)); ld_data = $urandom;
      start    = ($urandom_range(7) == 0);
      cpu_halt = (halt_at != 0 && run_seen + 1 == halt_at);
      @(negedge clk);
      vectors++;
      if ({ld_ready, rom_we} !== 2'b00) begin
        miscompares++;
        $display("FAIL no_load_after_image: ld_ready/rom_we=%b want 00", {ld_ready, rom_we});
      end
      if (cpu_rst === 1'b1) hold_seen++;
      else if (cpu_stall === 1'b0) run_seen++;
      else begin
        ended = 1'b1;
        break;
      end
    end
    start = 1'b0; cpu_halt = 1'b0; ld_valid = 1'b0;
    vectors++;
    if (!ended || hold_seen != HOLD_CYCLES || run_seen != exp_run) begin
      miscompares++;
      $display("FAIL run_length: ended=%b hold=%0d run=%0d want 1 %0d %0d",
               ended, hold_seen, run_seen, HOLD_CYCLES, exp_run);
    end
    vectors++;
    if (cycles !== CNT_W'(exp_run) || timeout !== exp_to) begin
      miscompares++;
      $display("FAIL run_status: cycles=%0d timeout=%b want %0d %b", cycles, timeout, exp_run, exp_to);
    end
    vectors++;
    if ({busy, done, cpu_rst, cpu_stall, res_valid} !== 5'b10010 || dbg_raddr !== '0) begin
      miscompares++;
      $display("FAIL dump_entry: busy/done/cpu_rst/cpu_stall/res_valid=%b raddr=%0d want 10010 0",
               {busy, done, cpu_rst, cpu_stall, res_valid}, dbg_raddr);
    end
    mdl_cycles = exp_run;
    mdl_timeout = exp_to;
    $display("run: halt_at=%0d run_cycles=%0d timeout=%b", halt_at, run_seen, exp_to);
  endtask

  // From the negedge of the first DUMP cycle to DONE. Index stall_idx gets
  // res_ready low for stall_len beat cycles.
  task automatic dump_phase(input int stall_idx, input int stall_len, input bit rand_ready);
    logic [DATA_W-1:0] exp_data;
    bit rdy, beat_ok;
    int stalls;
    for (int i = 0; i < DUMP_REGS; i++) begin
      vectors++;
      if ({res_valid, cpu_stall, cpu_rst, busy} !== 4'b0101 || dbg_raddr !== REG_AW'(i)) begin
        miscompares++;
        $display("FAIL dump_addr: valid/stall/rst/busy=%b raddr=%0d want 0101 %0d",
                 {res_valid, cpu_stall, cpu_rst, busy}, dbg_raddr, i);
      end
      exp_data = regs_tb[i];
      beat_ok = 1'b0; stalls = 0;
      next_cycle();
      for (int c = 0; c < 40; c++) begin
        if (i == stall_idx) rdy = (stalls >= stall_len);
        else if (rand_ready) rdy = 1'($urandom_range(1));
        else rdy = 1'b1;
        res_ready = rdy;
        regs_tb[i] = $urandom;  // the captured value must not follow this
        @(negedge clk);
        vectors++;
        if ({res_valid, res_idx, res_data} !== {1'b1, REG_AW'(i), exp_data}) begin
          miscompares++;
          $display("FAIL dump_beat: got valid=%b idx=%0d data=%h want 1 %0d %h",
                   res_valid, res_idx, res_data, i, exp_data);
        end
        if (rdy) begin
          beat_ok = 1'b1;
          break;
        end
        stalls++;
        next_cycle();
      end
      if (!beat_ok) begin
        miscompares++;
        $display("FAIL dump_handshake: idx %0d never accepted", i);
      end
      $display("beat: idx=%0d data=%h stalls=%0d", i, exp_data, stalls);
      next_cycle();
      res_ready = rand_ready ? 1'($urandom_range(1)) : 1'b0;
      @(negedge clk);
    end
    res_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({done, busy, cpu_stall, cpu_rst, res_valid} !== 5'b10100 ||
          load_words !== (ADDR_W+1)'(mdl_load_words) || cycles !== CNT_W'(mdl_cycles) ||
          timeout !== mdl_timeout) begin
        miscompares++;
        $display("FAIL done_state: flags=%b lw=%0d cyc=%0d to=%b want 10100 %0d %0d %b",
                 {done, busy, cpu_stall, cpu_rst, res_valid}, load_words, cycles, timeout,
                 mdl_load_words, mdl_cycles, mdl_timeout);
      end
      next_cycle();
      @(negedge clk);
    end
  endtask

  task automatic randomize_image(input int n);
    for (int k = 0; k < n; k++) img[k] = $urandom;
  endtask

  task automatic randomize_regs();
    for (int k = 0; k < (1 << REG_AW); k++) regs_tb[k] = $urandom;
  endtask

  task automatic test_basic_timeout();
    img[0] = 32'h3401_1100; img[1] = 32'h3402_0020; img[2] = 32'h3403_ff00; img[3] = 32'h3404_ffff;
    for (int k = 0; k < (1 << REG_AW); k++) regs_tb[k] = 32'h1000 + k;
    load_image(4, 3, 1'b1);
    run_phase(0);
    dump_phase(2, 3, 1'b0);
  endtask

  task automatic test_halt_same_cycle();
    randomize_image(5); randomize_regs();
    load_image(5, 4, 1'b1);
    run_phase(RUN_CYCLES);
    dump_phase(-1, 0, 1'b1);
  endtask

  task automatic test_halt_early();
    int n;
    n = $urandom_range(8, 1);
    randomize_image(n); randomize_regs();
    load_image(n, n - 1, 1'b1);
    run_phase($urandom_range(RUN_CYCLES - 1, 1));
    dump_phase($urandom_range(DUMP_REGS - 1), $urandom_range(4, 1), 1'b1);
  endtask

  task automatic test_back_to_back();
    randomize_image(16); randomize_regs();
    load_image(16, 15, 1'b0);
    run_phase($urandom_range(150, 1));
    dump_phase(-1, 0, 1'b0);
  endtask

  task automatic test_overflow();
    randomize_image(1025); randomize_regs();
    load_image(1025, -1, 1'b1);
    vectors++;
    if (load_words !== 11'd1024) begin
      miscompares++;
      $display("FAIL overflow_words: load_words=%0d want 1024", load_words);
    end
    run_phase($urandom_range(120, 1));
    dump_phase(-1, 0, 1'b1);
  endtask

  task automatic test_reset_mid_load();
    randomize_image(3); randomize_regs();
    next_cycle();
    start = 1'b1;
    next_cycle();
    start = 1'b0; ld_valid = 1'b1; ld_last = 1'b0; ld_data = img[0];
    next_cycle();
    ld_data = img[1];
    @(negedge clk);
    vectors++;
    if (rom_we !== 1'b1 || rom_addr !== '0 || rom_wdata !== img[0]) begin
      miscompares++;
      $display("FAIL midload_w0: we=%b addr=%0d data=%h want 1 0 %h", rom_we, rom_addr, rom_wdata, img[0]);
    end
    next_cycle();
    rst = 1'b1; ld_data = $urandom;
    @(negedge clk);
    vectors++;
    if (rom_we !== 1'b1 || rom_addr !== ADDR_W'(1) || rom_wdata !== img[1]) begin
      miscompares++;
      $display("FAIL midload_w1: we=%b addr=%0d data=%h want 1 1 %h", rom_we, rom_addr, rom_wdata, img[1]);
    end
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if ({cpu_rst, busy, ld_ready, rom_we, done, cpu_stall} !== 6'b100000 || load_words !== '0) begin
        miscompares++;
        $display("FAIL midload_idle: flags=%b load_words=%0d want 100000 0",
                 {cpu_rst, busy, ld_ready, rom_we, done, cpu_stall}, load_words);
      end
      next_cycle();
    end
    ld_valid = 1'b0;
    @(negedge clk);
    load_image(3, 2, 1'b1);
    run_phase($urandom_range(RUN_CYCLES, 1));
    dump_phase(-1, 0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    cpu_halt = 1'b0; res_ready = 1'b0;
    for (int k = 0; k < (1 << REG_AW); k++) regs_tb[k] = '0;
    test_reset();
    test_basic_timeout();
    test_halt_same_cycle();
    test_halt_early();
    test_back_to_back();
    test_overflow();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
